// File: rtl/axi_slave_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the write controller and its master.
interface axi_slave_wr_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 write slave: one burst at a time, FIXED/INCR/WRAP address generation,
// word-granular strobed writes to a local memory port, OKAY/SLVERR/DECERR responses.
module axi_slave_wr_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    axi_slave_wr_ctrl_if.slave           axi,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    output logic [DATA_W/8-1:0]          mem_wstrb_o
);
    localparam int NB     = DATA_W / 8;
    localparam int NB_LOG = $clog2(NB);
    localparam int MA_W   = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_DEPTH * NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] R_OKAY   = 2'b00;
    localparam logic [1:0] R_SLVERR = 2'b10;
    localparam logic [1:0] R_DECERR = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [7:0]        beat_q, beat_d;
    logic [1:0]        err_q, err_d;
    logic              supp_q, supp_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              mem_we_q, mem_we_d;
    logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d;

    logic [ADDR_W-1:0] step, wrap_sz, wrap_lo, seq_nxt, addr_nxt, aw_step;
    logic              cfg_err, oob, last_beat;
    logic [1:0]        err_nxt;

    assign step    = ADDR_W'(1) << size_q;
    assign wrap_sz = step * (ADDR_W'(len_q) + ADDR_W'(1));
    assign wrap_lo = addr_q & ~(wrap_sz - ADDR_W'(1));
    assign seq_nxt = addr_q + step;

    always_comb begin
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (seq_nxt == wrap_lo + wrap_sz) ? wrap_lo : seq_nxt;
            default: addr_nxt = (addr_q & ~(step - ADDR_W'(1))) + step;
        endcase
    end

    // Illegal burst shapes: still drain every beat, but never touch memory.
    assign aw_step = ADDR_W'(1) << axi.awsize;
    assign cfg_err = (axi.awsize > 3'(NB_LOG))
                  || (axi.awburst == 2'b11)
                  || ((axi.awburst == 2'b10) &&
                      !((axi.awlen == 8'd1) || (axi.awlen == 8'd3) ||
                        (axi.awlen == 8'd7) || (axi.awlen == 8'd15)))
                  || ((axi.awburst == 2'b10) && (|(axi.awaddr & (aw_step - ADDR_W'(1)))));

    assign oob       = {1'b0, addr_q} >= MEM_BYTES;
    assign last_beat = (beat_q == len_q);

    always_comb begin
        if ((err_q == R_SLVERR) || (axi.wlast != last_beat)) err_nxt = R_SLVERR;
        else if (oob)                                        err_nxt = R_DECERR;
        else                                                 err_nxt = err_q;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        err_d       = err_q;
        supp_d      = supp_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        case (state_q)
            S_IDLE: if (axi.awvalid && awready_q) begin
                id_d      = axi.awid;
                addr_d    = axi.awaddr;
                len_d     = axi.awlen;
                size_d    = axi.awsize;
                burst_d   = axi.awburst;
                beat_d    = 8'd0;
                err_d     = cfg_err ? R_SLVERR : R_OKAY;
                supp_d    = cfg_err;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                state_d   = S_DATA;
            end
            S_DATA: if (axi.wvalid && wready_q) begin
                if (!supp_q && !oob) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = MA_W'(addr_q >> NB_LOG);
                    mem_wdata_d = axi.wdata;
                    mem_wstrb_d = axi.wstrb;
                end
                err_d = err_nxt;
                // The burst always ends on the beat count; wlast only feeds the error.
                if (last_beat) begin
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    bid_d    = id_q;
                    bresp_d  = err_nxt;
                    state_d  = S_RESP;
                end else begin
                    beat_d = beat_q + 8'd1;
                    addr_d = addr_nxt;
                end
            end
            S_RESP: if (axi.bready && bvalid_q) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            err_q       <= R_OKAY;
            supp_q      <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= R_OKAY;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            supp_q      <= supp_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
endmodule

// File: doc/axi_slave_wr_ctrl.md
Name: axi_slave_wr_ctrl

Overview:
AXI4 write-channel slave controller: the design-side stage that consumes the AW/W traffic driven by the bench BFM through the AXI interface and returns B responses. It accepts one burst at a time, generates per-beat addresses for FIXED, INCR and WRAP bursts, and issues word-granular writes with byte strobes to a downstream memory port. It reports OKAY, SLVERR or DECERR on the B channel.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (32 or 64); NB = DATA_W/8 bytes per beat
ID_W, 4, AXI ID width
MEM_DEPTH, 256, downstream memory depth in DATA_W words; valid byte range is 0 .. MEM_DEPTH*NB-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
awid  in  ID_W  write address ID
awaddr  in  ADDR_W  burst start byte address
awlen  in  8  beats-1
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_W  write data
wstrb  in  NB  byte strobes
wlast  in  1  last beat marker
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  response ID (captured awid)
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid  out  1  B valid
bready  in  1  B ready
mem_we  out  1  one-cycle write pulse
mem_addr  out  clog2(MEM_DEPTH)  word address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  NB  byte enables

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE; awready=1, wready=0, bvalid=0, bresp=00, bid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. Reset mid-burst abandons the burst: no B response, no further mem writes.
- FSM states: IDLE, DATA, RESP. awready=1 only in IDLE, wready=1 only in DATA, bvalid=1 only in RESP. All outputs are registered.
- IDLE: on awvalid&&awready, capture id/addr/len/size/burst, set beat_cnt=0 and err=OKAY, then go to DATA. W beats presented while in IDLE are not accepted (wready=0).
- Burst checks at AW acceptance. Any of the following sets err=SLVERR and suppresses every mem write in the burst, but all awlen+1 beats are still accepted:
  - awsize > log2(NB)
  - awburst=11
  - WRAP with awlen not in {1,3,7,15}
  - WRAP with awaddr not aligned to 1<<awsize
- DATA: each handshake (wvalid&&wready) is one beat at cur_addr:
  - mem_we=1 on the next cycle, with mem_addr=cur_addr>>log2(NB), mem_wdata=wdata, mem_wstrb=wstrb. Otherwise mem_we=0.
  - Back-to-back beats give back-to-back pulses, one write per cycle.
  - A beat whose cur_addr >= MEM_DEPTH*NB is suppressed, and err is raised to DECERR unless it is already SLVERR.
  - Error priority: SLVERR > DECERR > OKAY.
- Address generation, with S=1<<size:
  - FIXED: next=cur.
  - INCR: next=(cur & ~(S-1))+S. The first beat may be unaligned; subsequent beats are aligned.
  - WRAP: T=S*(len+1), lower=cur & ~(T-1); next=cur+S, or lower if cur+S == lower+T.
- wlast check: expected last is beat_cnt==len. If wlast does not match on any beat, err=SLVERR. Termination is always by count (len+1 beats); a premature wlast does not end the burst.
- After the final beat, go to RESP. bvalid rises on the cycle after the last W handshake, with bid=captured id and bresp=err.
- RESP: hold bvalid/bid/bresp stable until bready. On bvalid&&bready: bvalid=0, state=IDLE, awready=1 on the next cycle. No new AW is accepted while a response is pending.
- Minimum burst turnaround with full-rate handshakes: AW(1) + beats(len+1) + B(1) cycles.

Test Plan:
- INCR single: awaddr=0x10, len=0, size=2, wdata=0xDEADBEEF, wstrb=F -> mem_we pulse with mem_addr=4, data 0xDEADBEEF; bresp=00, bid=awid.
- INCR unaligned: awaddr=0x02, len=2, size=2 -> mem_addr 0,1,2 on consecutive cycles; bresp=00.
- WRAP: awaddr=0x38, len=3, size=2 -> byte addresses 0x38, 0x3C, 0x30, 0x34 (mem_addr 14,15,12,13); FIXED len=3 at 0x20 -> mem_addr 8 four times.
- Errors:
  - awsize=3 with DATA_W=32 -> 4 beats accepted, no mem_we, bresp=10.
  - awaddr=0x3FC, len=1, MEM_DEPTH=256 -> first beat written at mem_addr 255, second suppressed, bresp=11.
  - wlast asserted on beat 1 of 4 -> all 4 beats accepted, bresp=10.
- Backpressure: wvalid toggled every other cycle and bready held low 5 cycles -> bvalid/bid/bresp stable throughout, awready=0 until the cycle after the B handshake.
- Reset mid-burst: rst=1 after beat 2 of 8 -> all outputs at reset values next cycle; a new burst after rst=0 completes normally with bresp=00.
